btn_dir_ctrl: RTL and testbench
===============================

Name: btn_dir_ctrl

Overview:
Consumes the 20 kHz slow clock produced by the divider stage and uses its rising edge as a sample tick for the five board push-buttons. The block debounces the buttons and emits one-cycle press pulses. It also maintains a validated snake-direction request, with 180° reversal rejection, for the game-logic stage. Everything runs in the CLOCK domain; the 20 kHz signal is only ever sampled as data, never used as a clock.

Parameters:
DEBOUNCE_SAMPLES, 400, consecutive differing 20 kHz samples required to accept a new button level (400 = 20 ms).
CNT_W, 9, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_SAMPLES.

Ports:
CLOCK  in  1  system clock (100 MHz).
RESET_N  in  1  reset; asynchronous assert, active-low.
CLK_20kHz  in  1  slow clock level from the divider; sampled as data.
BTN  in  5  raw buttons: [0]=up, [1]=down, [2]=left, [3]=right, [4]=centre; asynchronous to CLOCK.
BTN_PRESS  out  5  one-CLOCK pulse per button on a debounced 0->1 transition.
START_PULSE  out  1  equals BTN_PRESS[4].
DIR  out  2  requested heading: 00=up, 01=down, 10=left, 11=right.
DIR_VALID  out  1  a new, not-yet-consumed direction is pending.
DIR_ACK  in  1  game stage consumes DIR this cycle.

Behaviour:
- Reset (async, RESET_N=0):
  - All sync flops, the CLK_20kHz history flop, debounce counters and stable levels clear to 0.
  - BTN_PRESS=0, DIR_VALID=0.
  - Committed heading = 11 (right), so DIR=11.
- Input synchronisation: BTN passes through a 2-flop synchroniser. Tick = CLK_20kHz & ~clk20_d, asserted for exactly one CLOCK cycle per rising edge of the slow clock.
- Debounce, per button:
  - On tick, if the synchronised level differs from the stable level, cnt increments. When cnt reaches DEBOUNCE_SAMPLES-1 and the level still differs, the stable level flips and cnt is cleared.
  - On tick, if the synchronised level equals the stable level, cnt is cleared.
  - Between ticks, nothing changes.
- Press pulse: BTN_PRESS[i]=1 in the CLOCK cycle immediately after stable[i] goes 0->1. Release (1->0) produces no pulse. Latency from the accepting tick is 1 cycle.
- Direction request, state IDLE (DIR_VALID=0) or PENDING (DIR_VALID=1):
  - Candidate = highest-priority direction press in this cycle; priority up>down>left>right.
  - Reference heading = the pending direction if ACK is not asserted with VALID high in this cycle; otherwise the value being committed this cycle.
  - The candidate is accepted if it is neither equal to nor the opposite of the reference heading. Acceptance sets pending=candidate and DIR_VALID=1; while PENDING, latest accepted press wins.
  - DIR_ACK with DIR_VALID=1: committed <= pending. DIR_VALID clears unless a candidate is accepted in the same cycle, in which case it stays 1 with the new value.
  - DIR_ACK with DIR_VALID=0 is ignored.
  - DIR = pending while DIR_VALID=1, otherwise committed.
- Opposites: up<->down, left<->right.
- Centre button has no effect on direction.
- Reset mid-operation: in-flight debounce and any pending direction are discarded. A button held across reset release must complete a full DEBOUNCE_SAMPLES window and then produces a press.
- Counters never wrap: cnt is bounded by DEBOUNCE_SAMPLES-1.

Decomposition:
- Shared package snake_pkg:
  - direction encoding constants DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT;
  - button index constants BTN_UP..BTN_CTR;
  - an is_opposite function.
- One sub-module btn_debounce_cell (synchroniser, counter, stable level, rise pulse), instantiated 5x and sharing the tick.
- Direction FSM and tick edge-detect live in the top module.

Test Plan:
Bench drives CLK_20kHz toggling every 4 CLOCK cycles (tick every 8) with DEBOUNCE_SAMPLES=4.
1. Reset then idle -> DIR=11, DIR_VALID=0, BTN_PRESS=00000. Assert RESET_N=0 mid-run -> outputs return to these values with no CLOCK edge.
2. Hold BTN[0] high for 4 ticks -> exactly one BTN_PRESS[0] pulse, 1 cycle after the 4th tick. Then DIR=00, DIR_VALID=1. Release produces no pulse.
3. BTN[1] bounces 1,0,1 across 3 ticks, then holds -> counter restarts; press occurs only after 4 consecutive high ticks.
4. Heading right committed, press left -> ignored (DIR_VALID stays 0). Press right -> ignored. Press up -> DIR=00, DIR_VALID=1.
5. Pending up, press left then ack -> DIR=10 before ack. After ack, committed=10, DIR_VALID=0.
6. Pending up; same cycle: DIR_ACK=1 plus down press -> down rejected (opposite of up), DIR_VALID=0. Repeat with left press -> DIR=10, DIR_VALID=1. Simultaneous up+left press from IDLE with heading right -> up wins.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the button/direction front end of the snake game:
// heading codes, button indices and the reversal test.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } dir_state_e;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_CTR   = 4;
  localparam int NUM_BTN   = 5;

  // Opposite headings share the axis bit [1] and differ in the sense bit [0].
  function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One push-button: two-flop synchroniser, tick-qualified debounce counter,
// stable level and a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce_cell #(
  parameter int DEBOUNCE_SAMPLES = 400,
  parameter int CNT_W            = 9
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SAMPLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick_i) begin
      if (sync2_q != stable_q) begin
        // The comparison is >= so the counter can never run past its limit.
        if (cnt_q >= CNT_MAX) begin
          stable_d = ~stable_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
    press_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/btn_dir_ctrl.sv
// Button front end: debounces the five board buttons on the 20 kHz sample tick
// and turns direction presses into a validated, reversal-free heading request.
module btn_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 400,
  parameter int CNT_W            = 9
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       CLK_20kHz,
  input  logic [4:0] BTN,
  output logic [4:0] BTN_PRESS,
  output logic       START_PULSE,
  output logic [1:0] DIR,
  output logic       DIR_VALID,
  input  logic       DIR_ACK
);

  logic       clk20_q;
  logic       tick;
  dir_state_e state_q;
  dir_state_e state_d;
  dir_e       pending_q;
  dir_e       pending_d;
  dir_e       committed_q;
  dir_e       committed_d;
  dir_e       cand;
  dir_e       ref_dir;
  logic       cand_valid;
  logic       accept;

  // The slow clock is data only; its rising edge becomes a one-cycle tick.
  assign tick = CLK_20kHz & ~clk20_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce_cell #(
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES),
        .CNT_W           (CNT_W)
      ) u_cell (
        .clk_i  (CLOCK),
        .rst_ni (RESET_N),
        .tick_i (tick),
        .btn_i  (BTN[gi]),
        .press_o(BTN_PRESS[gi])
      );
    end
  endgenerate

  assign START_PULSE = BTN_PRESS[BTN_CTR];

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    committed_d = committed_q;
    cand        = DIR_UP;
    cand_valid  = 1'b1;
    if (BTN_PRESS[BTN_UP])         cand = DIR_UP;
    else if (BTN_PRESS[BTN_DOWN])  cand = DIR_DOWN;
    else if (BTN_PRESS[BTN_LEFT])  cand = DIR_LEFT;
    else if (BTN_PRESS[BTN_RIGHT]) cand = DIR_RIGHT;
    else                           cand_valid = 1'b0;

    // An ack commits the pending value, so the reference is the same either way.
    ref_dir = (state_q == ST_PENDING) ? pending_q : committed_q;
    accept  = cand_valid && (cand != ref_dir) && !is_opposite(cand, ref_dir);

    if (DIR_ACK && (state_q == ST_PENDING)) begin
      committed_d = pending_q;
      state_d     = ST_IDLE;
    end
    if (accept) begin
      pending_d = cand;
      state_d   = ST_PENDING;
    end

    DIR_VALID = (state_q == ST_PENDING);
    DIR       = (state_q == ST_PENDING) ? pending_q : committed_q;
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      clk20_q     <= 1'b0;
      state_q     <= ST_IDLE;
      pending_q   <= DIR_UP;
      committed_q <= DIR_RIGHT;
    end else begin
      clk20_q     <= CLK_20kHz;
      state_q     <= state_d;
      pending_q   <= pending_d;
      committed_q <= committed_d;
    end
  end

endmodule

// File: tb/tb_btn_dir_ctrl.sv
// Scoreboard bench for btn_dir_ctrl: stimulus queues expected press pulses and
// {DIR_VALID,DIR} changes; a monitor pops and compares them as they appear.
module tb_btn_dir_ctrl;

  localparam int NS = 4;

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       CLK_20kHz = 1'b0;
  logic [4:0] BTN = 5'b0;
  logic       DIR_ACK = 1'b0;
  logic [4:0] BTN_PRESS;
  logic       START_PULSE;
  logic [1:0] DIR;
  logic       DIR_VALID;

  typedef struct {
    logic [4:0] vec;
    int         tick;
  } press_t;

  press_t     press_q[$];
  logic [2:0] dir_q[$];
  int         checks = 0;
  int         passes = 0;
  int         rise_cnt = 0;

  btn_dir_ctrl #(.DEBOUNCE_SAMPLES(NS), .CNT_W(3)) dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .CLK_20kHz  (CLK_20kHz),
    .BTN        (BTN),
    .BTN_PRESS  (BTN_PRESS),
    .START_PULSE(START_PULSE),
    .DIR        (DIR),
    .DIR_VALID  (DIR_VALID),
    .DIR_ACK    (DIR_ACK)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    forever begin
      repeat (4) @(negedge CLOCK);
      CLK_20kHz = ~CLK_20kHz;
      if (CLK_20kHz) rise_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every press pulse and every change of {DIR_VALID,DIR} is an output event.
  initial begin
    logic [2:0] prev;
    press_t     e;
    prev = 3'b011;
    forever begin
      @(negedge CLOCK);
      if (RESET_N) begin
        if (BTN_PRESS != 5'b0) begin
          if (press_q.size() == 0) begin
            check("unexpected_press", 32'(BTN_PRESS), 32'h0);
          end else begin
            e = press_q.pop_front();
            check("press_vec", 32'(BTN_PRESS), 32'(e.vec));
            check("press_tick", rise_cnt, e.tick);
            check("start_pulse", 32'(START_PULSE), 32'(e.vec[4]));
            $display("press %b at tick %0d", BTN_PRESS, rise_cnt);
          end
        end
        if ({DIR_VALID, DIR} != prev) begin
          if (dir_q.size() == 0) begin
            check("unexpected_dir", 32'({DIR_VALID, DIR}), 32'(prev));
          end else begin
            check("dir_event", 32'({DIR_VALID, DIR}), 32'(dir_q.pop_front()));
            $display("dir change valid=%b dir=%b", DIR_VALID, DIR);
          end
        end
      end
      prev = {DIR_VALID, DIR};
    end
  end

  task automatic wait_rise();
    int t = rise_cnt;
    wait (rise_cnt != t);
    @(negedge CLOCK);
  endtask

  // Hold vec for NS ticks; optional ack lands in the same cycle as the press pulse.
  task automatic press(input logic [4:0] vec, input logic ack_same,
                       input logic has_dir, input logic [2:0] dir_evt);
    int     r;
    press_t e;
    wait_rise();
    r      = rise_cnt;
    e.vec  = vec;
    e.tick = r + NS;
    press_q.push_back(e);
    if (has_dir) dir_q.push_back(dir_evt);
    BTN = vec;
    while (rise_cnt < r + NS) wait_rise();
    if (ack_same) DIR_ACK = 1'b1;
    @(negedge CLOCK);
    DIR_ACK = 1'b0;
    BTN     = 5'b0;
    repeat (NS + 1) wait_rise();
  endtask

  task automatic ack();
    @(negedge CLOCK);
    DIR_ACK = 1'b1;
    @(negedge CLOCK);
    DIR_ACK = 1'b0;
    repeat (2) @(negedge CLOCK);
  endtask

  initial begin
    int     r;
    press_t e;
    repeat (3) @(negedge CLOCK);
    check("reset_dir", 32'(DIR), 32'h3);
    check("reset_valid", 32'(DIR_VALID), 32'h0);
    check("reset_press", 32'(BTN_PRESS), 32'h0);
    RESET_N = 1'b1;

    // Heading right: left (reverse) and right (same) ignored, up accepted.
    press(5'b00100, 1'b0, 1'b0, 3'b000);
    press(5'b01000, 1'b0, 1'b0, 3'b000);
    press(5'b00001, 1'b0, 1'b1, 3'b100);

    // Asynchronous reset with up pending, checked before any clock edge.
    @(negedge CLOCK);
    #1 RESET_N = 1'b0;
    #1;
    check("midrst_dir", 32'(DIR), 32'h3);
    check("midrst_valid", 32'(DIR_VALID), 32'h0);
    check("midrst_press", 32'(BTN_PRESS), 32'h0);
    repeat (2) @(negedge CLOCK);
    RESET_N = 1'b1;

    // Simultaneous up+left from idle: up wins. Then left overrides pending up.
    press(5'b00101, 1'b0, 1'b1, 3'b100);
    press(5'b00100, 1'b0, 1'b1, 3'b110);
    dir_q.push_back(3'b010);
    ack();
    ack();

    // Ack coincident with a press: down rejected against up, left accepted.
    press(5'b00001, 1'b0, 1'b1, 3'b100);
    press(5'b00010, 1'b1, 1'b1, 3'b000);
    press(5'b00100, 1'b0, 1'b1, 3'b110);
    dir_q.push_back(3'b010);
    ack();
    press(5'b00001, 1'b0, 1'b1, 3'b100);
    press(5'b00100, 1'b1, 1'b1, 3'b110);
    dir_q.push_back(3'b010);
    ack();

    // Down bounces 1,0,1 then holds: the press needs NS consecutive high ticks.
    wait_rise();
    r      = rise_cnt;
    e.vec  = 5'b00010;
    e.tick = r + 2 + NS;
    press_q.push_back(e);
    dir_q.push_back(3'b101);
    BTN = 5'b00010;
    wait_rise();
    BTN = 5'b00000;
    wait_rise();
    BTN = 5'b00010;
    while (rise_cnt < r + 2 + NS) wait_rise();
    @(negedge CLOCK);
    BTN = 5'b0;
    repeat (NS + 1) wait_rise();
    dir_q.push_back(3'b001);
    ack();

    repeat (20) @(negedge CLOCK);
    check("press_queue_drained", press_q.size(), 0);
    check("dir_queue_drained", dir_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
